maxpool_2x2_engine: RTL and testbench

Downstream stage of the convolution result memory. Once the convolution stage has filled the IN_DIM×IN_DIM result buffer, this block reads it back, computes a 2×2, stride-2 signed max-pool, and writes OUT_DIM×OUT_DIM pooled values into the pooling result memory. It is a single-pass, start/done-controlled engine with a fixed, deterministic schedule.

---
 rtl/maxpool_pkg.sv | 16 +
 rtl/maxpool_addr_gen.sv | 73 +++++++
 rtl/maxpool_2x2_engine.sv | 148 ++++++++++++++
 tb/tb_maxpool_2x2_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and default sizing for the conv -> max-pool memory pipeline.
package maxpool_pkg;

    localparam int unsigned MP_DATA_WIDTH    = 16;
    localparam int unsigned MP_IN_DIM        = 26;
    localparam int unsigned MP_RD_ADDR_WIDTH = 10;
    localparam int unsigned MP_WR_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mp_state_e;

endpackage

// File: rtl/maxpool_addr_gen.sv
// Raster-order 2x2/stride-2 window read address generator (tap, pcol, prow counters).
module maxpool_addr_gen
    import maxpool_pkg::*;
#(
    parameter int unsigned IN_DIM        = MP_IN_DIM,
    parameter int unsigned RD_ADDR_WIDTH = MP_RD_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     adv_i,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [1:0]               tap_o,
    output logic                     last_read_o
);

    localparam int unsigned OUT_DIM = IN_DIM / 2;
    localparam int unsigned CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0]            IDX_LAST = CW'(OUT_DIM - 1);
    localparam logic [RD_ADDR_WIDTH-1:0] ROW_STEP = RD_ADDR_WIDTH'(2 * IN_DIM);
    localparam logic [RD_ADDR_WIDTH-1:0] IN_STEP  = RD_ADDR_WIDTH'(IN_DIM);

    logic [1:0]    tap_q, tap_d;
    logic [CW-1:0] pcol_q, pcol_d;
    logic [CW-1:0] prow_q, prow_d;
    logic          col_end, row_end;

    assign col_end = (pcol_q == IDX_LAST);
    assign row_end = (prow_q == IDX_LAST);

    always_comb begin
        tap_d  = tap_q;
        pcol_d = pcol_q;
        prow_d = prow_q;
        if (clr_i) begin
            tap_d  = '0;
            pcol_d = '0;
            prow_d = '0;
        end else if (adv_i) begin
            tap_d = tap_q + 2'd1;
            if (tap_q == 2'd3) begin
                if (col_end) begin
                    pcol_d = '0;
                    prow_d = row_end ? '0 : prow_q + CW'(1);
                end else begin
                    pcol_d = pcol_q + CW'(1);
                end
            end
        end
    end

    // Tap order 0,1,2,3 maps to base, base+1, base+IN_DIM, base+IN_DIM+1.
    assign rd_addr_o = RD_ADDR_WIDTH'(prow_q) * ROW_STEP
                     + (RD_ADDR_WIDTH'(pcol_q) << 1)
                     + (tap_q[1] ? IN_STEP : '0)
                     + RD_ADDR_WIDTH'(tap_q[0]);

    assign tap_o       = tap_q;
    assign last_read_o = (tap_q == 2'd3) && col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q  <= '0;
            pcol_q <= '0;
            prow_q <= '0;
        end else begin
            tap_q  <= tap_d;
            pcol_q <= pcol_d;
            prow_q <= prow_d;
        end
    end

endmodule

// File: rtl/maxpool_2x2_engine.sv
// Start/done controlled 2x2 stride-2 signed max-pool engine between conv and pool memories.
module maxpool_2x2_engine
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MP_DATA_WIDTH,
    parameter int unsigned IN_DIM        = MP_IN_DIM,
    parameter int unsigned RD_ADDR_WIDTH = MP_RD_ADDR_WIDTH,
    parameter int unsigned WR_ADDR_WIDTH = MP_WR_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     wr_en,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data
);

    localparam int unsigned OUT_DIM = IN_DIM / 2;
    localparam logic [WR_ADDR_WIDTH-1:0] LAST_W = WR_ADDR_WIDTH'(OUT_DIM * OUT_DIM - 1);

    mp_state_e state_q, state_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]               rd_tap_q;
    logic                     dv_q;
    logic [1:0]               dtap_q;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic                     wr_en_q;
    logic [WR_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [WR_ADDR_WIDTH-1:0] widx_q;

    logic                     issue;
    logic                     gen_clr, gen_adv, gen_last;
    logic [RD_ADDR_WIDTH-1:0] gen_addr;
    logic [1:0]               gen_tap;
    logic                     win_end;

    maxpool_addr_gen #(
        .IN_DIM        (IN_DIM),
        .RD_ADDR_WIDTH (RD_ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (gen_clr),
        .adv_i       (gen_adv),
        .rd_addr_o   (gen_addr),
        .tap_o       (gen_tap),
        .last_read_o (gen_last)
    );

    // The start cycle already issues tap 0, so the generator is held cleared whenever not reading.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        gen_clr = 1'b0;
        gen_adv = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    issue   = 1'b1;
                    gen_adv = 1'b1;
                    state_d = READ;
                end else begin
                    gen_clr = 1'b1;
                end
            end
            READ: begin
                issue   = 1'b1;
                gen_adv = 1'b1;
                if (gen_last) state_d = DRAIN;
            end
            DRAIN: begin
                gen_clr = 1'b1;
                if (wr_en_q && (wr_addr_q == LAST_W)) state_d = DONE;
            end
            DONE: begin
                gen_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == READ) || (state_d == DRAIN);
        done_d = (state_q == DRAIN) && (state_d == DONE);
    end

    // First tap of a window loads unconditionally; later taps replace only when strictly greater.
    always_comb begin
        acc_d = acc_q;
        if (dtap_q == 2'd0 || ($signed(rd_data) > $signed(acc_q))) acc_d = rd_data;
    end

    assign win_end = dv_q && (dtap_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_tap_q  <= '0;
            dv_q      <= 1'b0;
            dtap_q    <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            widx_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= issue;
            if (issue) begin
                rd_addr_q <= gen_addr;
                rd_tap_q  <= gen_tap;
            end
            dv_q   <= rd_en_q;
            dtap_q <= rd_tap_q;
            if (dv_q) acc_q <= acc_d;
            wr_en_q <= win_end;
            if (win_end) begin
                wr_addr_q <= widx_q;
                wr_data_q <= acc_d;
                widx_q    <= widx_q + WR_ADDR_WIDTH'(1);
            end
            if (state_q == IDLE) widx_q <= '0;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_2x2_engine.sv
// Scoreboard bench for maxpool_2x2_engine: a default 26x26 instance and a 5x5 instance.
module tb_maxpool_2x2_engine;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          addr;
        logic [15:0] v;
    } hand_t;

    logic        clk;
    logic        rst;
    logic        start, start2;
    logic        busy, done, rd_en, wr_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data, wr_data;
    logic [7:0]  wr_addr;
    logic        busy2, done2, rd_en2, wr_en2;
    logic [4:0]  rd_addr2;
    logic [15:0] rd_data2, wr_data2;
    logic [1:0]  wr_addr2;

    logic [15:0] mem  [0:1023];
    logic [15:0] mem2 [0:31];
    logic [15:0] got  [0:255];

    exp_t  wq[$];
    exp_t  wq2[$];
    int    rq2[$];
    hand_t hq[$];

    // driver-owned
    int pe_t0, rst_at, exp_nwr, exp_nwr2, exp_nrd2, exp_done_cyc, exp_done2_cyc;
    bit exp_done, exp_done2, rd_ok, rd_ok2, chk_reset, end_req, timeout;
    // monitor-owned
    int total, bad, n_wr, n_wr2, n_rd2, mcyc;
    bit done_seen, done2_seen;
    // clock-edge counter
    int pe;

    maxpool_2x2_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    maxpool_2x2_engine #(
        .DATA_WIDTH    (16),
        .IN_DIM        (5),
        .RD_ADDR_WIDTH (5),
        .WR_ADDR_WIDTH (2)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .busy    (busy2),
        .done    (done2),
        .rd_en   (rd_en2),
        .rd_addr (rd_addr2),
        .rd_data (rd_data2),
        .wr_en   (wr_en2),
        .wr_addr (wr_addr2),
        .wr_data (wr_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial pe = 0;
    always @(posedge clk) pe <= pe + 1;

    // synchronous read memories, one cycle latency
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en2) rd_data2 <= mem2[rd_addr2];
    end

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, want, mcyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, mcyc);
    endtask

    // ---------------- monitor ----------------
    initial begin
        total = 0; bad = 0; n_wr = 0; n_wr2 = 0; n_rd2 = 0; mcyc = 0;
        done_seen = 0; done2_seen = 0;
    end

    always @(negedge clk) begin
        exp_t  e;
        hand_t h;
        mcyc = pe - pe_t0 + 1;
        if (chk_reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst2_busy", busy2, 0);
            chk("rst2_rd_en", rd_en2, 0);
            chk("rst2_wr_en", wr_en2, 0);
        end
        if (rd_en && !rd_ok) fail_now("unexpected_read");
        if (wr_en) begin
            n_wr++;
            got[wr_addr] = wr_data;
            if (wq.size() == 0) fail_now("unexpected_write");
            else begin
                e = wq.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", $signed(wr_data), $signed(e.data));
                chk("wr_cycle", mcyc, e.cyc);
                chk("busy_at_write", busy, 1);
            end
        end
        if (done) begin
            if (!exp_done) fail_now("unexpected_done");
            else begin
                chk("done_cycle", mcyc, exp_done_cyc);
                chk("busy_at_done", busy, 0);
            end
            done_seen = 1;
        end
        if (rst_at > 0 && mcyc > rst_at && mcyc <= rst_at + 10) begin
            chk("rd_en_after_rst", rd_en, 0);
            chk("wr_en_after_rst", wr_en, 0);
        end
        if (rd_en2) begin
            n_rd2++;
            if (!rd_ok2 || rq2.size() == 0) fail_now("unexpected_read2");
            else chk("rd_addr2", rd_addr2, rq2.pop_front());
        end
        if (wr_en2) begin
            n_wr2++;
            if (wq2.size() == 0) fail_now("unexpected_write2");
            else begin
                e = wq2.pop_front();
                chk("wr_addr2", wr_addr2, e.addr);
                chk("wr_data2", $signed(wr_data2), $signed(e.data));
                chk("wr_cycle2", mcyc, e.cyc);
            end
        end
        if (done2) begin
            if (!exp_done2) fail_now("unexpected_done2");
            else chk("done2_cycle", mcyc, exp_done2_cyc);
            done2_seen = 1;
        end
        if (timeout) fail_now("timeout");
        if (end_req) begin
            chk("writes_left", wq.size(), 0);
            chk("write_count", n_wr, exp_nwr);
            chk("done_seen", done_seen, exp_done);
            chk("writes2_left", wq2.size(), 0);
            chk("reads2_left", rq2.size(), 0);
            chk("write2_count", n_wr2, exp_nwr2);
            chk("read2_count", n_rd2, exp_nrd2);
            chk("done2_seen", done2_seen, exp_done2);
            while (hq.size() > 0) begin
                h = hq.pop_front();
                chk($sformatf("hand_win%0d", h.addr), $signed(got[h.addr]), $signed(h.v));
            end
            n_wr = 0; n_wr2 = 0; n_rd2 = 0;
            done_seen = 0; done2_seen = 0;
        end
    end

    // ---------------- driver ----------------
    function automatic logic [15:0] model_max(input int w);
        int prow, pcol, base, best, v;
        int offs[4];
        prow = w / 13;
        pcol = w % 13;
        base = 2 * prow * 26 + 2 * pcol;
        offs = '{0, 1, 26, 27};
        best = -40000;
        foreach (offs[k]) begin
            v = $signed(mem[base + offs[k]]);
            if (v > best) best = v;
        end
        return 16'(best);
    endfunction

    task automatic add_hand(input int a, input logic [15:0] v);
        hand_t h;
        h.addr = a;
        h.v    = v;
        hq.push_back(h);
    endtask

    task automatic finish_pass();
        start = 0; start2 = 0; rd_ok = 0; rd_ok2 = 0;
        repeat (4) @(posedge clk);
        #1;
        end_req = 1;
        @(posedge clk); #1;
        end_req = 0; timeout = 0; rst_at = 0;
        exp_done = 0; exp_done2 = 0; exp_nwr = 0; exp_nwr2 = 0; exp_nrd2 = 0;
    endtask

    task automatic run_pass(input int rst_at_i, input int s1, input int s2);
        exp_t e;
        int   c;
        bit   fin;
        exp_nwr = 0;
        for (int w = 0; w < 169; w++) begin
            if (rst_at_i == 0 || 4 * w + 6 <= rst_at_i) begin
                e.addr = w;
                e.data = model_max(w);
                e.cyc  = 4 * w + 6;
                wq.push_back(e);
                exp_nwr++;
            end
        end
        exp_done     = (rst_at_i == 0);
        exp_done_cyc = 679;
        rst_at       = rst_at_i;
        rd_ok        = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        pe_t0 = pe;
        fin = 0;
        while (!fin) begin
            @(posedge clk); #1;
            c = pe - pe_t0 + 1;
            start = (c == s1 || c == s2);
            if (rst_at_i > 0) begin
                if (c == rst_at_i) rst = 1;
                if (c == rst_at_i + 1) begin
                    rst   = 0;
                    rd_ok = 0;
                end
                if (c == rst_at_i + 12) fin = 1;
            end else if (done_seen) begin
                fin   = 1;
                rd_ok = 0;
            end
            if (c > 1000) begin
                timeout = 1;
                fin     = 1;
            end
        end
        finish_pass();
    endtask

    task automatic run_small();
        exp_t e;
        int   c;
        bit   fin;
        int   ra[16];
        int   wd[4];
        ra = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
        wd = '{6, 8, 16, 18};
        foreach (ra[k]) rq2.push_back(ra[k]);
        foreach (wd[k]) begin
            e.addr = k;
            e.data = 16'(wd[k]);
            e.cyc  = 4 * k + 6;
            wq2.push_back(e);
        end
        exp_nrd2 = 16; exp_nwr2 = 4; exp_done2 = 1; exp_done2_cyc = 19; rd_ok2 = 1;
        @(posedge clk); #1;
        start2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        pe_t0 = pe;
        fin = 0;
        while (!fin) begin
            @(posedge clk); #1;
            c = pe - pe_t0 + 1;
            if (done2_seen) fin = 1;
            if (c > 200) begin
                timeout = 1;
                fin     = 1;
            end
        end
        finish_pass();
    endtask

    initial begin
        rst = 1; start = 0; start2 = 0;
        pe_t0 = 0; rst_at = 0; exp_nwr = 0; exp_nwr2 = 0; exp_nrd2 = 0;
        exp_done_cyc = 0; exp_done2_cyc = 0;
        exp_done = 0; exp_done2 = 0; rd_ok = 0; rd_ok2 = 0;
        chk_reset = 0; end_req = 0; timeout = 0;
        for (int a = 0; a < 32; a++) mem2[a] = 16'(a);

        repeat (3) @(posedge clk);
        #1;
        chk_reset = 1;
        @(posedge clk); #1;
        chk_reset = 0;
        rst = 0;

        // ramp data
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
        add_hand(0, 16'd27);
        add_hand(168, 16'd675);
        run_pass(0, 0, 0);

        // all-negative data: taps of window 0 are -1000,-999,-995,-994
        for (int a = 0; a < 1024; a++) mem[a] = 16'(-1000 + (a % 7));
        add_hand(0, 16'hFC1E);
        run_pass(0, 0, 0);

        // mixed sign: positive 3 must beat 0x8000; window 1 is all 0x8000
        for (int a = 0; a < 1024; a++) mem[a] = (a % 5 == 0) ? 16'd3 : 16'h8000;
        add_hand(0, 16'd3);
        add_hand(1, 16'h8000);
        run_pass(0, 0, 0);

        // start pulses while reading and while in DONE are ignored
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
        add_hand(0, 16'd27);
        run_pass(0, 100, 679);

        // reset mid-pass, then a full pass on negative data
        run_pass(300, 0, 0);
        for (int a = 0; a < 1024; a++) mem[a] = 16'(-1000 + (a % 7));
        add_hand(0, 16'hFC1E);
        run_pass(0, 0, 0);

        // 5x5 instance: odd edge row/column ignored
        run_small();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
